// File: rtl/npc_pkg.sv
// Shared types and constants for the next-PC generator.
// Used by npc and npc_target_calc via import npc_pkg::*.
package npc_pkg;

    typedef logic [31:0] addr_t;

    localparam addr_t PC_INC = 32'd4;

    typedef enum logic [1:0] {
        SRC_PC4    = 2'd0,
        SRC_BRANCH = 2'd1,
        SRC_JUMP   = 2'd2,
        SRC_JR     = 2'd3
    } npc_src_e;

    // Number of control-transfer flags that are high.
    function automatic logic [2:0] flag_count(input logic a, input logic b,
                                              input logic c, input logic d);
        return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    endfunction

endpackage

// File: rtl/npc_target_calc.sv
// Combinational candidate addresses: sequential (PC+4), branch and jump targets.
// All arithmetic wraps modulo 2^32.
module npc_target_calc
    import npc_pkg::*;
(
    input  logic [31:0] PC,
    input  logic [31:0] offset,
    input  logic [25:0] instr_index,
    output logic [31:0] pc4,
    output logic [31:0] branch_target,
    output logic [31:0] jump_target
);

    addr_t w_pc4;
    addr_t w_offset_bytes;

    assign w_pc4          = PC + PC_INC;
    // The word-to-byte shift drops offset[31:30]; those bits are sign copies anyway.
    assign w_offset_bytes = offset << 2;

    assign pc4           = w_pc4;
    assign branch_target = w_pc4 + w_offset_bytes;
    assign jump_target   = {w_pc4[31:28], instr_index, 2'b00};

endmodule

// File: rtl/npc.sv
// Next-PC generator: priority select (jr > jal > bgtz > beq), redirect counter,
// and an optional sticky conflicting-flag error enabled by NPC_SEL_CHECK_EN.
module npc
    import npc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        zero,
    input  logic        greater,
    input  logic [31:0] PC,
    input  logic [31:0] offset,
    input  logic [31:0] jr_add,
    input  logic [25:0] instr_index,
    input  logic        beq,
    input  logic        bgtz,
    input  logic        jal,
    input  logic        jr,
    output logic [31:0] NPC,
    output logic [31:0] link_addr,
    output logic        redirect,
    output logic [31:0] redirect_cnt
`ifdef NPC_SEL_CHECK_EN
    ,
    output logic        sel_err
`endif
);

    addr_t    w_pc4;
    addr_t    w_branch_target;
    addr_t    w_jump_target;
    npc_src_e w_src;
    addr_t    r_redirect_cnt;

    npc_target_calc u_target_calc (
        .PC            (PC),
        .offset        (offset),
        .instr_index   (instr_index),
        .pc4           (w_pc4),
        .branch_target (w_branch_target),
        .jump_target   (w_jump_target)
    );

    always_comb begin
        w_src = SRC_PC4;
        if (jr) begin
            w_src = SRC_JR;
        end else if (jal) begin
            w_src = SRC_JUMP;
        end else if (bgtz && greater) begin
            w_src = SRC_BRANCH;
        end else if (beq && zero) begin
            w_src = SRC_BRANCH;
        end
    end

    always_comb begin
        NPC = w_pc4;
        unique case (w_src)
            SRC_PC4:    NPC = w_pc4;
            SRC_BRANCH: NPC = w_branch_target;
            SRC_JUMP:   NPC = w_jump_target;
            SRC_JR:     NPC = jr_add;
            default:    NPC = w_pc4;
        endcase
    end

    assign link_addr = w_pc4;
    assign redirect  = (w_src != SRC_PC4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_cnt <= '0;
        end else if (redirect) begin
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
        end
    end

    assign redirect_cnt = r_redirect_cnt;

`ifdef NPC_SEL_CHECK_EN
    logic w_multi_flag;
    logic r_sel_err;

    assign w_multi_flag = (flag_count(beq, bgtz, jal, jr) > 3'd1);

    // Sticky: once a decode conflict is seen it stays visible until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (w_multi_flag) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err = r_sel_err;
`endif

endmodule

// File: tb/tb_npc.sv
// Self-checking bench for npc: directed vector table, reset/count sequences,
// and randomized stimulus against a behavioural next-PC model.
module tb_npc;

    logic        clk;
    logic        rst_n;
    logic        zero, greater;
    logic [31:0] PC, offset, jr_add;
    logic [25:0] instr_index;
    logic        beq, bgtz, jal, jr;
    logic [31:0] NPC, link_addr, redirect_cnt;
    logic        redirect;
`ifdef NPC_SEL_CHECK_EN
    logic        sel_err;
`endif

    npc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .zero         (zero),
        .greater      (greater),
        .PC           (PC),
        .offset       (offset),
        .jr_add       (jr_add),
        .instr_index  (instr_index),
        .beq          (beq),
        .bgtz         (bgtz),
        .jal          (jal),
        .jr           (jr),
        .NPC          (NPC),
        .link_addr    (link_addr),
        .redirect     (redirect),
        .redirect_cnt (redirect_cnt)
`ifdef NPC_SEL_CHECK_EN
        ,
        .sel_err      (sel_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] off;
        logic [31:0] jra;
        logic [25:0] idx;
        logic [3:0]  flags;   // {jr, jal, bgtz, beq}
        logic        z;
        logic        g;
        logic [31:0] exp_npc;
        logic        exp_redir;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_cnt  = 0;
    logic        exp_err  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: the spec's rules written with plain arithmetic.
    function automatic logic [31:0] model_npc(input vec_t v);
        logic [31:0] seq, br, jt;
        seq = v.pc + 32'd4;
        br  = seq + v.off * 32'd4;
        jt  = (seq & 32'hF000_0000) | ({6'd0, v.idx} * 32'd4);
        if (v.flags[3])               return v.jra;
        if (v.flags[2])               return jt;
        if (v.flags[1] && v.g)        return br;
        if (v.flags[0] && v.z)        return br;
        return seq;
    endfunction

    function automatic logic model_redir(input vec_t v);
        return v.flags[3] | v.flags[2] | (v.flags[1] & v.g) | (v.flags[0] & v.z);
    endfunction

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] off,
                                input logic [31:0] jra, input logic [25:0] idx,
                                input logic [3:0] flags, input logic z, input logic g,
                                input logic [31:0] en, input logic er);
        vec_t v;
        v.pc = pc; v.off = off; v.jra = jra; v.idx = idx; v.flags = flags;
        v.z = z; v.g = g; v.exp_npc = en; v.exp_redir = er;
        return v;
    endfunction

    // Called at posedge+1; leaves at the following posedge+1.
    task automatic apply(input vec_t v, input string tag);
        int nflags;
        PC = v.pc; offset = v.off; jr_add = v.jra; instr_index = v.idx;
        {jr, jal, bgtz, beq} = v.flags; zero = v.z; greater = v.g;
        #1;
        chk({tag, ".npc"},      NPC,        v.exp_npc);
        chk({tag, ".link"},     link_addr,  v.pc + 32'd4);
        chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, v.exp_redir});
        @(posedge clk);
        nflags = int'(v.flags[0]) + int'(v.flags[1]) + int'(v.flags[2]) + int'(v.flags[3]);
        if (rst_n) begin
            if (v.exp_redir) exp_cnt = exp_cnt + 32'd1;
            if (nflags > 1)  exp_err = 1'b1;
        end
        #1;
        chk({tag, ".cnt"}, redirect_cnt, exp_cnt);
`ifdef NPC_SEL_CHECK_EN
        chk({tag, ".sel_err"}, {31'd0, sel_err}, {31'd0, exp_err});
`endif
        $display("%s pc=%08h flags=%b npc=%08h redir=%0d cnt=%0d",
                 tag, v.pc, v.flags, NPC, redirect, redirect_cnt);
    endtask

    vec_t tbl[12];

    initial begin
        vec_t v;
        rst_n = 1'b0;
        zero = 0; greater = 0; PC = 0; offset = 0; jr_add = 0; instr_index = 0;
        beq = 0; bgtz = 0; jal = 0; jr = 0;

        tbl[0]  = mk(32'h1234_5678, 32'd8, 32'h0, 26'h0, 4'b0000, 0, 0, 32'h1234_567C, 0);
        tbl[1]  = mk(32'h1234_5678, 32'd8, 32'h0, 26'h0, 4'b0001, 1, 0, 32'h1234_569C, 1);
        tbl[2]  = mk(32'h1234_5678, 32'd8, 32'h0, 26'h0, 4'b0010, 0, 0, 32'h1234_567C, 0);
        tbl[3]  = mk(32'h1234_5678, 32'd8, 32'h0, 26'h0, 4'b0010, 0, 1, 32'h1234_569C, 1);
        tbl[4]  = mk(32'h1234_5678, 32'd8, 32'h0, 26'h00_000A, 4'b0100, 0, 0, 32'h1000_0028, 1);
        tbl[5]  = mk(32'h1234_5678, 32'd8, 32'h8765_4321, 26'h0, 4'b1000, 0, 0, 32'h8765_4321, 1);
        tbl[6]  = mk(32'h0000_0000, 32'hFFFF_FFFE, 32'h0, 26'h0, 4'b0001, 1, 0, 32'hFFFF_FFFC, 1);
        tbl[7]  = mk(32'h1234_5678, 32'd8, 32'h0, 26'h0, 4'b0001, 0, 1, 32'h1234_567C, 0);
        tbl[8]  = mk(32'hFFFF_FFFC, 32'd8, 32'h0, 26'h0, 4'b0000, 1, 1, 32'h0000_0000, 0);
        tbl[9]  = mk(32'hF000_0000, 32'd0, 32'h0, 26'h3FF_FFFF, 4'b0100, 0, 0, 32'hFFFF_FFFC, 1);
        tbl[10] = mk(32'h0040_0000, 32'h4000_0001, 32'h0, 26'h1, 4'b0110, 0, 1, 32'h0000_0004, 1);
        tbl[11] = mk(32'h1234_5678, 32'd8, 32'h8765_4321, 26'h0, 4'b1001, 1, 0, 32'h8765_4321, 1);

        #2;
        chk("reset.cnt", redirect_cnt, 32'd0);
`ifdef NPC_SEL_CHECK_EN
        chk("reset.sel_err", {31'd0, sel_err}, 32'd0);
`endif
        #10 rst_n = 1'b1;             // released at t=12, between edges
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Hold a taken beq: count must step once per edge.
        for (int i = 0; i < 4; i++) apply(tbl[1], $sformatf("hold%0d", i));

        // Asynchronous reset mid-count clears count and error immediately.
        #2 rst_n = 1'b0;
        exp_cnt = 0; exp_err = 0;
        #1;
        chk("async_rst.cnt", redirect_cnt, 32'd0);
`ifdef NPC_SEL_CHECK_EN
        chk("async_rst.sel_err", {31'd0, sel_err}, 32'd0);
`endif
        @(posedge clk); #1;
        apply(tbl[11], "in_rst");     // counter held at 0 during reset
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        exp_cnt = 32'd1;              // that edge counted tbl[11] still on the inputs
        chk("resume.cnt", redirect_cnt, exp_cnt);
`ifdef NPC_SEL_CHECK_EN
        exp_err = 1'b1;
        chk("resume.sel_err", {31'd0, sel_err}, {31'd0, exp_err});
`endif
        apply(tbl[1], "resume1");

        for (int i = 0; i < 200; i++) begin
            v.pc    = $urandom;
            v.off   = ($urandom_range(0, 1) == 0) ? $urandom : {{16{1'b1}}, 16'($urandom)};
            v.jra   = $urandom;
            v.idx   = 26'($urandom);
            v.flags = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
            v.z     = 1'($urandom);
            v.g     = 1'($urandom);
            v.exp_npc   = model_npc(v);
            v.exp_redir = model_redir(v);
            apply(v, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npc.md
# npc

Next-PC generator for the single-cycle MIPS datapath. It sits between the PC register and the instruction-fetch path. From the current PC, the decoded control-transfer flags (beq, bgtz, jal, jr) and the ALU comparison flags, it computes the address of the next instruction. It also keeps a small clocked count of redirected fetches for debug and performance visibility.

## Interface
- No parameters; all widths are fixed at the MIPS-32 values.
- clk  in  1  rising-edge clock for the internal counters and flags.
- rst_n  in  1  reset, asynchronous and active-low.
- zero  in  1  ALU equality flag (rs == rt).
- greater  in  1  ALU flag for rs > 0 (signed).
- PC  in  32  current instruction address.
- offset  in  32  sign-extended 16-bit branch immediate, in words.
- jr_add  in  32  register value used as the jr target.
- instr_index  in  26  J-format target field.
- beq, bgtz, jal, jr  in  1 each  decoded instruction flags.
- NPC  out  32  next instruction address (combinational).
- link_addr  out  32  PC + 4, the value jal writes to $31 (combinational).
- redirect  out  1  high when NPC is not PC + 4 because of a control transfer (combinational).
- redirect_cnt  out  32  registered count of cycles with redirect high.
- sel_err  out  1  registered conflicting-flag error; present only with NPC_SEL_CHECK_EN.

## Operation
- pc4 = PC + 4, modulo 2^32.
- Branch target = pc4 + (offset << 2), modulo 2^32; offset bits [31:30] are discarded by the shift.
- Jump target = {pc4[31:28], instr_index, 2'b00}.
- Flag priority when several are high: jr > jal > bgtz > beq.
  - jr: NPC = jr_add, passed through unmodified with no alignment masking.
  - jal: NPC = jump target.
  - bgtz with greater = 1: NPC = branch target.
  - beq with zero = 1: NPC = branch target.
  - Otherwise NPC = pc4. This includes an untaken branch, where redirect = 0.
- redirect = jr | jal | (bgtz & greater) | (beq & zero).
- redirect_cnt increments by 1 on each rising clk edge while redirect = 1. It wraps from 0xFFFFFFFF to 0.

## Timing
- NPC, link_addr and redirect are purely combinational with zero-cycle latency. They must be valid within the same cycle for the PC register to capture them.
- redirect_cnt and sel_err update on the rising edge of clk.
- Reset: rst_n low asynchronously forces redirect_cnt = 0 and sel_err = 0. Combinational outputs are unaffected by reset.
- If rst_n is asserted mid-count, the count is lost. Counting resumes from 0 on the first rising edge after rst_n goes high.
- There is no handshake; inputs are sampled continuously.

## Configuration
- Macro: NPC_SEL_CHECK_EN.
- Defined:
  - sel_err is set on a rising edge when more than one of beq, bgtz, jal, jr is high.
  - It is sticky until reset.
  - NPC still follows the priority order above.
- Undefined:
  - The sel_err port and its logic are omitted.
  - NPC behaviour is identical.

## Structure
- Shared package holds:
  - PC_INC = 32'd4;
  - a next-PC source enum (SRC_PC4, SRC_BRANCH, SRC_JUMP, SRC_JR);
  - the 32-bit address typedef.
- One natural sub-module: npc_target_calc.
  - Purely combinational.
  - Produces pc4, the branch target and the jump target.
  - The top level does selection, the counter and the error flag.

## Test plan
- PC=0x12345678, offset=8, all flags 0 → NPC=0x1234567C, link_addr=0x1234567C, redirect=0.
- Same PC/offset, beq=1, zero=1 → NPC=0x1234569C, redirect=1; redirect_cnt increments once per clock while held.
- bgtz=1, greater=0 → NPC=0x1234567C; then greater=1 → NPC=0x1234569C.
- jal=1, instr_index=0x000000A → NPC=0x10000028.
- jr=1, jr_add=0x87654321 → NPC=0x87654321.
- jr=1 and beq=1, zero=1:
  - NPC=0x87654321 (jr wins).
  - With NPC_SEL_CHECK_EN, sel_err=1 after the next edge and stays 1.
  - Asserting rst_n low immediately clears sel_err and redirect_cnt to 0.
- Negative offset 0xFFFFFFFE with PC=0 and beq/zero → NPC=0xFFFFFFFC, showing the wrap-around.
